// File: rtl/fan_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// fan_cfg_sequencer
//   Front-end sequencer for the fan controller. Synchronises the byte strobe and
//   config-enable pins, splits the byte stream into configuration frames and
//   measurement samples, commits complete frames atomically into the active
//   PID/PWM registers and generates the periodic PID update tick.
//
// Ports
//   clk           system clock
//   rst           asynchronous reset, active high
//   data_i        byte bus (must be stable around the strobe edge)
//   data_valid_i  byte strobe, asynchronous; a synced 0->1 edge accepts a byte
//   config_en_i   config-enable, asynchronous; high = bytes are configuration
//   setpoint_o    active setpoint
//   kp_o/ki_o/kd_o active PID gains
//   meas_o        last measurement byte
//   meas_stb_o    1-cycle pulse when meas_o updates
//   pid_tick_o    1-cycle PID evaluation enable, every PID_CLK_DIV+1 cycles
//   cfg_busy_o    high while a frame is being collected
//   cfg_done_o    1-cycle pulse on frame commit
//   cfg_err_o     1-cycle pulse on aborted frame
// -----------------------------------------------------------------------------
module fan_cfg_sequencer #(
    parameter logic [16:0] PID_CLK_DIV  = 17'd99_999,
    parameter int unsigned CFG_BYTES    = 4,
    parameter logic [7:0]  RST_SETPOINT = 8'd0,
    parameter logic [7:0]  RST_GAIN     = 8'd16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       data_valid_i,
    input  logic       config_en_i,
    output logic [7:0] setpoint_o,
    output logic [7:0] kp_o,
    output logic [7:0] ki_o,
    output logic [7:0] kd_o,
    output logic [7:0] meas_o,
    output logic       meas_stb_o,
    output logic       pid_tick_o,
    output logic       cfg_busy_o,
    output logic       cfg_done_o,
    output logic       cfg_err_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN} state_t;

    localparam logic [2:0] CFG_N = 3'(CFG_BYTES);

    // valid_sync: [0]=first stage, [1]=synced level, [2]=previous synced level
    logic [2:0]       valid_sync_q, valid_sync_d;
    logic [1:0]       cfg_sync_q, cfg_sync_d;
    logic             accept_q, accept_d;
    logic [7:0]       byte_q, byte_d;
    logic             byte_cfg_q, byte_cfg_d;
    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [3:0][7:0]  shadow_q, shadow_d;
    logic [7:0]       setpoint_q, setpoint_d, kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
    logic [7:0]       meas_q, meas_d;
    logic             meas_stb_q, meas_stb_d;
    logic [16:0]      pid_cnt_q, pid_cnt_d;
    logic             pid_tick_q, pid_tick_d;
    logic             cfg_done_q, cfg_done_d;
    logic             cfg_err_q, cfg_err_d;

    logic             cfg_level;
    logic             store;
    logic             take_meas;

    assign cfg_level = cfg_sync_q[1];

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        valid_sync_d = {valid_sync_q[1:0], data_valid_i};
        cfg_sync_d   = {cfg_sync_q[0], config_en_i};
        accept_d     = valid_sync_q[1] & ~valid_sync_q[2];
        // Byte and its config flag are frozen on the accept cycle.
        byte_d       = accept_d ? data_i : byte_q;
        byte_cfg_d   = accept_d ? cfg_sync_q[1] : byte_cfg_q;

        state_d    = state_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        setpoint_d = setpoint_q;
        kp_d       = kp_q;
        ki_d       = ki_q;
        kd_d       = kd_q;
        meas_d     = meas_q;
        meas_stb_d = 1'b0;
        cfg_done_d = 1'b0;
        cfg_err_d  = 1'b0;
        store      = 1'b0;
        take_meas  = 1'b0;

        if (pid_cnt_q == PID_CLK_DIV) begin
            pid_cnt_d  = '0;
            pid_tick_d = 1'b1;
        end else begin
            pid_cnt_d  = pid_cnt_q + 17'd1;
            pid_tick_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_q) begin
                    store     = byte_cfg_q;
                    take_meas = ~byte_cfg_q;
                end
            end
            ST_LOAD: begin
                // A config drop mid-frame wins over any byte in flight.
                if (!cfg_level) begin
                    cfg_err_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else if (accept_q && byte_cfg_q) begin
                    store = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!cfg_level) begin
                    state_d   = ST_IDLE;
                    take_meas = accept_q & ~byte_cfg_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (take_meas) begin
            meas_d     = byte_q;
            meas_stb_d = 1'b1;
        end

        if (store) begin
            shadow_d[cnt_q[1:0]] = byte_q;
            if (cnt_q + 3'd1 == CFG_N) begin
                // Commit: all active registers load together from the shadow.
                setpoint_d = shadow_d[0];
                if (CFG_N > 3'd1) kp_d = shadow_d[1];
                if (CFG_N > 3'd2) ki_d = shadow_d[2];
                if (CFG_N > 3'd3) kd_d = shadow_d[3];
                cfg_done_d = 1'b1;
                cnt_d      = '0;
                state_d    = ST_DRAIN;
                pid_cnt_d  = '0;
                pid_tick_d = 1'b0;
            end else begin
                cnt_d   = cnt_q + 3'd1;
                state_d = ST_LOAD;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_sync_q <= '0;
            cfg_sync_q   <= '0;
            accept_q     <= 1'b0;
            byte_q       <= '0;
            byte_cfg_q   <= 1'b0;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            setpoint_q   <= RST_SETPOINT;
            kp_q         <= RST_GAIN;
            ki_q         <= RST_GAIN;
            kd_q         <= RST_GAIN;
            meas_q       <= '0;
            meas_stb_q   <= 1'b0;
            pid_cnt_q    <= '0;
            pid_tick_q   <= 1'b0;
            cfg_done_q   <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            valid_sync_q <= valid_sync_d;
            cfg_sync_q   <= cfg_sync_d;
            accept_q     <= accept_d;
            byte_q       <= byte_d;
            byte_cfg_q   <= byte_cfg_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            setpoint_q   <= setpoint_d;
            kp_q         <= kp_d;
            ki_q         <= ki_d;
            kd_q         <= kd_d;
            meas_q       <= meas_d;
            meas_stb_q   <= meas_stb_d;
            pid_cnt_q    <= pid_cnt_d;
            pid_tick_q   <= pid_tick_d;
            cfg_done_q   <= cfg_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    // NOTE: the shadow store has no reset; each slot is written before a commit can read it.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    assign setpoint_o = setpoint_q;
    assign kp_o       = kp_q;
    assign ki_o       = ki_q;
    assign kd_o       = kd_q;
    assign meas_o     = meas_q;
    assign meas_stb_o = meas_stb_q;
    assign pid_tick_o = pid_tick_q;
    assign cfg_busy_o = (state_q == ST_LOAD);
    assign cfg_done_o = cfg_done_q;
    assign cfg_err_o  = cfg_err_q;

endmodule

// File: tb/tb_fan_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fan_cfg_sequencer
//   Self-checking bench for fan_cfg_sequencer. A transaction-level model derives
//   every output from the raw pin history (fixed pipeline latency) plus a frame
//   queue and a cycles-since-reload count for the tick; one compare process
//   checks all outputs each cycle. Directed scenarios pin the model with literal
//   values, then randomized traffic runs against it.
// -----------------------------------------------------------------------------
module tb_fan_cfg_sequencer;

    localparam logic [16:0] DIV = 17'd9;
    localparam int          CB  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_i;
    logic       data_valid_i, config_en_i;
    logic [7:0] setpoint_o, kp_o, ki_o, kd_o, meas_o;
    logic       meas_stb_o, pid_tick_o, cfg_busy_o, cfg_done_o, cfg_err_o;

    fan_cfg_sequencer #(
        .PID_CLK_DIV (DIV),
        .CFG_BYTES   (CB),
        .RST_SETPOINT(8'd0),
        .RST_GAIN    (8'd16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_i      (data_i),
        .data_valid_i(data_valid_i),
        .config_en_i (config_en_i),
        .setpoint_o  (setpoint_o),
        .kp_o        (kp_o),
        .ki_o        (ki_o),
        .kd_o        (kd_o),
        .meas_o      (meas_o),
        .meas_stb_o  (meas_stb_o),
        .pid_tick_o  (pid_tick_o),
        .cfg_busy_o  (cfg_busy_o),
        .cfg_done_o  (cfg_done_o),
        .cfg_err_o   (cfg_err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // History index k = raw pin value sampled k edges ago (0 = this edge).
    logic [4:0] vh, ch;
    logic [7:0] dh0, dh1;
    logic [7:0] frame[$];
    bit         draining;
    int         since_reload;
    logic [7:0] m_sp, m_kp, m_ki, m_kd, m_meas;
    bit         m_meas_stb, m_done, m_err, m_tick, m_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            vh = '0; ch = '0; dh0 = '0; dh1 = '0;
            frame.delete();
            draining = 0; since_reload = 0;
            m_sp = 8'd0; m_kp = 8'd16; m_ki = 8'd16; m_kd = 8'd16; m_meas = 8'd0;
            m_meas_stb = 0; m_done = 0; m_err = 0; m_tick = 0; m_busy = 0;
        end else begin
            bit       acc, bcfg, lvl, commit;
            logic [7:0] d;
            vh  = {vh[3:0], data_valid_i};
            ch  = {ch[3:0], config_en_i};
            dh1 = dh0;
            dh0 = data_i;
            // A byte reaches the outputs three edges after the raw strobe edge;
            // its config flag is the pin as it stood at the strobe edge, and the
            // config level the sequencer reacts to lags the pin by two edges.
            acc  = vh[3] && !vh[4];
            bcfg = ch[3];
            lvl  = ch[2];
            d    = dh1;
            m_meas_stb = 0; m_done = 0; m_err = 0; commit = 0;
            since_reload++;
            m_tick = (since_reload % (int'(DIV) + 1)) == 0;

            if (frame.size() > 0) begin
                if (!lvl) begin
                    m_err = 1;
                    frame.delete();
                end else if (acc && bcfg) begin
                    frame.push_back(d);
                end
            end else if (draining) begin
                if (!lvl) begin
                    draining = 0;
                    if (acc && !bcfg) begin m_meas = d; m_meas_stb = 1; end
                end
            end else if (acc) begin
                if (bcfg) frame.push_back(d);
                else begin m_meas = d; m_meas_stb = 1; end
            end

            if (frame.size() == CB) begin
                m_sp = frame[0]; m_kp = frame[1]; m_ki = frame[2]; m_kd = frame[3];
                frame.delete();
                m_done = 1; draining = 1;
                since_reload = 0; m_tick = 0;
            end
            m_busy = frame.size() > 0;
        end
    end

    // ---------------- compare / monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc++;

    int done_cnt = 0, err_cnt = 0;
    int last_tick = -1000, tick_gap = 0;
    int last_done = 0, tick_after_done = 0;
    bit want_tick_after_done = 0;

    always @(negedge clk) begin
        if (!rst) begin
            check("setpoint", setpoint_o, m_sp);
            check("kp", kp_o, m_kp);
            check("ki", ki_o, m_ki);
            check("kd", kd_o, m_kd);
            check("meas", meas_o, m_meas);
            check("meas_stb", meas_stb_o, m_meas_stb);
            check("pid_tick", pid_tick_o, m_tick);
            check("cfg_busy", cfg_busy_o, m_busy);
            check("cfg_done", cfg_done_o, m_done);
            check("cfg_err", cfg_err_o, m_err);
            if (cfg_done_o) begin
                done_cnt++;
                last_done = cyc;
                want_tick_after_done = 1;
            end
            if (cfg_err_o) err_cnt++;
            if (pid_tick_o) begin
                tick_gap  = cyc - last_tick;
                last_tick = cyc;
                if (want_tick_after_done) begin
                    tick_after_done = cyc - last_done;
                    want_tick_after_done = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] d, input logic cfg);
        @(negedge clk);
        data_i = d;
        config_en_i = cfg;
        @(negedge clk);
        data_valid_i = 1'b1;
        repeat (4) @(negedge clk);
        data_valid_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic drop_cfg(input int wait_cyc);
        @(negedge clk);
        config_en_i = 1'b0;
        repeat (wait_cyc) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        data_i = '0; data_valid_i = 1'b0; config_en_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Give meas_o a non-reset value so the reset check has something to clear.
        send_byte(8'h77, 1'b0);
        check("pre_reset_meas", meas_o, 8'h77);

        // T1: async reset mid-cycle, then tick period.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t1_setpoint", setpoint_o, 0);
        check("t1_kp", kp_o, 16);
        check("t1_ki", ki_o, 16);
        check("t1_kd", kd_o, 16);
        check("t1_meas", meas_o, 0);
        check("t1_strobes", {meas_stb_o, pid_tick_o, cfg_busy_o, cfg_done_o, cfg_err_o}, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("t1_no_tick_in_reset", pid_tick_o, 0);
        end
        rst = 1'b0;
        repeat (25) @(negedge clk);
        check("t1_tick_period", tick_gap, 10);

        // T2: full frame; busy while collecting.
        send_byte(8'd100, 1'b1);
        check("t2_busy_b1", cfg_busy_o, 1);
        send_byte(8'd20, 1'b1);
        check("t2_busy_b2", cfg_busy_o, 1);
        send_byte(8'd5, 1'b1);
        check("t2_busy_b3", cfg_busy_o, 1);
        check("t2_no_early_update", kp_o, 16);
        send_byte(8'd2, 1'b1);
        check("t2_done_cnt", done_cnt, 1);
        check("t2_busy_after", cfg_busy_o, 0);
        check("t2_setpoint", setpoint_o, 100);
        check("t2_kp", kp_o, 20);
        check("t2_ki", ki_o, 5);
        check("t2_kd", kd_o, 2);
        // T6: next tick comes a full period after the commit.
        repeat (12) @(negedge clk);
        check("t6_tick_after_commit", tick_after_done, 10);
        drop_cfg(4);

        // T3: aborted frame.
        send_byte(8'd80, 1'b1);
        send_byte(8'd30, 1'b1);
        drop_cfg(5);
        check("t3_err_cnt", err_cnt, 1);
        check("t3_setpoint_kept", setpoint_o, 100);
        check("t3_kd_kept", kd_o, 2);

        // T4: measurement latency, exactly 3 edges after the raw strobe edge.
        @(negedge clk);
        data_i = 8'd50; config_en_i = 1'b0;
        @(negedge clk);
        data_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_stb_not_early", meas_stb_o, 0);
        @(negedge clk);
        check("t4_stb", meas_stb_o, 1);
        check("t4_meas", meas_o, 50);
        data_valid_i = 1'b0;
        @(negedge clk);
        check("t4_stb_one_cycle", meas_stb_o, 0);
        repeat (2) @(negedge clk);

        // T5: overrun byte ignored in drain.
        send_byte(8'd10, 1'b1);
        send_byte(8'd11, 1'b1);
        send_byte(8'd12, 1'b1);
        send_byte(8'd13, 1'b1);
        send_byte(8'd99, 1'b1);
        drop_cfg(4);
        check("t5_setpoint", setpoint_o, 10);
        check("t5_kp", kp_o, 11);
        check("t5_ki", ki_o, 12);
        check("t5_kd", kd_o, 13);
        check("t5_no_err", err_cnt, 1);
        check("t5_done_cnt", done_cnt, 2);

        // Randomized traffic against the model.
        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind <= 3) begin
                send_byte(8'($urandom), 1'b0);
            end else if (kind <= 5) begin
                for (int b = 0; b < CB; b++) send_byte(8'($urandom), 1'b1);
                drop_cfg($urandom_range(3, 6));
            end else if (kind <= 7) begin
                int len;
                len = $urandom_range(1, CB - 1);
                for (int b = 0; b < len; b++) send_byte(8'($urandom), 1'b1);
                drop_cfg($urandom_range(3, 6));
            end else if (kind == 8) begin
                int extra;
                extra = $urandom_range(1, 2);
                for (int b = 0; b < CB + extra; b++) send_byte(8'($urandom), 1'b1);
                drop_cfg($urandom_range(3, 6));
            end else begin
                // Reset in the middle of a frame.
                send_byte(8'($urandom), 1'b1);
                send_byte(8'($urandom), 1'b1);
                #2 rst = 1'b1;
                config_en_i = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                repeat (2) @(negedge clk);
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
